// File: rtl/playback_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// playback_pkg
// Shared definitions for the playback sequencer:
//   state_t          - state codes, also driven onto the status LEDs
//   NUM_SONGS_DEF    - default number of selectable songs
//   RST_CYCLES_DEF   - default hold time of reset_player per song change
//   step_song()      - song index increment/decrement with power-of-two wrap
// -----------------------------------------------------------------------------
package playback_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED    = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_RESETTING = 2'd2,
        ST_ILLEGAL   = 2'd3
    } state_t;

    localparam int unsigned NUM_SONGS_DEF  = 4;
    localparam int unsigned RST_CYCLES_DEF = 2;

    // Wrap is done by masking, so the song count must be a power of two.
    function automatic logic [1:0] step_song(input logic [1:0] cur,
                                             input logic       up,
                                             input logic [1:0] mask);
        logic [1:0] nxt;
        nxt = up ? (cur + 2'd1) : (cur - 2'd1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// -----------------------------------------------------------------------------
// playback_sequencer_if
// Bundles the user/song-reader controls and the sequencer outputs.
//   play_button, next_button, prev_button : one-cycle pulses from the UI
//   auto_advance                          : level, continue on song_done
//   song_done                             : one-cycle pulse from song reader
//   play, song, reset_player, status      : registered sequencer outputs
// Modports:
//   master - the sequencer (drives outputs, samples controls)
//   slave  - the environment (drives controls, samples outputs)
// -----------------------------------------------------------------------------
interface playback_sequencer_if;

    logic       play_button;
    logic       next_button;
    logic       prev_button;
    logic       auto_advance;
    logic       song_done;

    logic       play;
    logic [1:0] song;
    logic       reset_player;
    logic [1:0] status;

    modport master (
        input  play_button, next_button, prev_button, auto_advance, song_done,
        output play, song, reset_player, status
    );

    modport slave (
        output play_button, next_button, prev_button, auto_advance, song_done,
        input  play, song, reset_player, status
    );

endinterface

// File: rtl/playback_sequencer.sv
// -----------------------------------------------------------------------------
// playback_sequencer
// Play/pause and song-select controller in front of a song reader. Every song
// change passes through RESETTING, which holds reset_player for RST_CYCLES
// cycles and then resumes or pauses depending on the state it was entered from.
//
// Ports:
//   clk    - clock, all logic on posedge
//   reset  - synchronous active-high reset
//   bus    - playback_sequencer_if.master (controls in, registered outputs)
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_PAUSED    | idle, play=0, waits for play/next/prev
// ST_PLAYING   | play=1, song reader running
// ST_RESETTING | reset_player=1 for RST_CYCLES cycles, all inputs ignored
// ST_ILLEGAL   | unreachable code, falls back to ST_PAUSED
// -----------------------------------------------------------------------------
module playback_sequencer
    import playback_pkg::*;
#(
    parameter int unsigned NUM_SONGS  = NUM_SONGS_DEF,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    playback_sequencer_if.master    bus
);

    localparam logic [1:0] SONG_MASK = 2'(NUM_SONGS - 1);
    // The entry cycle itself counts as the first RESETTING cycle.
    localparam logic [3:0] CNT_LOAD  = 4'(RST_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] song_q,  song_d;
    logic       resume_q, resume_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       play_q,  reset_player_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_PAUSED;
            song_q         <= 2'd0;
            resume_q       <= 1'b0;
            cnt_q          <= 4'd0;
            play_q         <= 1'b0;
            reset_player_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            song_q         <= song_d;
            resume_q       <= resume_d;
            cnt_q          <= cnt_d;
            play_q         <= (state_d == ST_PLAYING);
            reset_player_q <= (state_d == ST_RESETTING);
        end
    end

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        resume_d = resume_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_PAUSED, ST_PLAYING: begin
                if (bus.next_button) begin
                    state_d  = ST_RESETTING;
                    song_d   = step_song(song_q, 1'b1, SONG_MASK);
                    resume_d = (state_q == ST_PLAYING);
                    cnt_d    = CNT_LOAD;
                end else if (bus.prev_button) begin
                    state_d  = ST_RESETTING;
                    song_d   = step_song(song_q, 1'b0, SONG_MASK);
                    resume_d = (state_q == ST_PLAYING);
                    cnt_d    = CNT_LOAD;
                end else if (bus.song_done && state_q == ST_PLAYING) begin
                    // Without auto_advance the same song restarts, paused.
                    state_d  = ST_RESETTING;
                    song_d   = bus.auto_advance ?
                               step_song(song_q, 1'b1, SONG_MASK) : song_q;
                    resume_d = bus.auto_advance;
                    cnt_d    = CNT_LOAD;
                end else if (bus.play_button) begin
                    state_d = (state_q == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
                end
            end
            ST_RESETTING: begin
                if (cnt_q == 4'd0) begin
                    state_d = resume_q ? ST_PLAYING : ST_PAUSED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_PAUSED;
            end
        endcase
    end

    assign bus.play         = play_q;
    assign bus.song         = song_q;
    assign bus.reset_player = reset_player_q;
    assign bus.status       = state_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_playback_sequencer
// Directed test of playback_sequencer with default parameters (4 songs,
// 2-cycle reset hold). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so each check sees the registered
// response to the pulse applied in the preceding cycle.
// -----------------------------------------------------------------------------
module tb_playback_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    playback_sequencer_if bus ();

    playback_sequencer #(
        .NUM_SONGS  (4),
        .RST_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Checks play, song, reset_player and status together.
    task automatic chk_out(input string tag, input int p, input int s,
                           input int rp, input int st);
        chk({tag, ".play"},         int'(bus.play),         p);
        chk({tag, ".song"},         int'(bus.song),         s);
        chk({tag, ".reset_player"}, int'(bus.reset_player), rp);
        chk({tag, ".status"},       int'(bus.status),       st);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on any combination of the pulse inputs.
    task automatic pulse(input logic nx, input logic pv, input logic dn,
                         input logic pb);
        bus.next_button = nx;
        bus.prev_button = pv;
        bus.song_done   = dn;
        bus.play_button = pb;
        step();
        bus.next_button = 1'b0;
        bus.prev_button = 1'b0;
        bus.song_done   = 1'b0;
        bus.play_button = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset            = 1'b1;
        bus.play_button  = 1'b0;
        bus.next_button  = 1'b0;
        bus.prev_button  = 1'b0;
        bus.auto_advance = 1'b0;
        bus.song_done    = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_out("reset", 0, 0, 0, 0);
        step();
        step();
        chk_out("idle", 0, 0, 0, 0);

        // play from PAUSED
        pulse(0, 0, 0, 1);
        chk_out("play", 1, 0, 0, 1);

        // next while PLAYING: 2 cycles of RESETTING, then resume
        pulse(1, 0, 0, 0);
        chk_out("next_r1", 0, 1, 1, 2);
        step();
        chk_out("next_r2", 0, 1, 1, 2);
        step();
        chk_out("next_resume", 1, 1, 0, 1);

        // prev while PLAYING back to song 0, then pause
        pulse(0, 1, 0, 0);
        chk_out("prev_play_r1", 0, 0, 1, 2);
        step();
        step();
        chk_out("prev_play_resume", 1, 0, 0, 1);
        pulse(0, 0, 0, 1);
        chk_out("pause", 0, 0, 0, 0);

        // prev while PAUSED wraps 0 -> 3 and returns to PAUSED
        pulse(0, 1, 0, 0);
        chk_out("prev_wrap_r1", 0, 3, 1, 2);
        step();
        chk_out("prev_wrap_r2", 0, 3, 1, 2);
        step();
        chk_out("prev_wrap_pause", 0, 3, 0, 0);

        // song_done with auto_advance wraps 3 -> 0 and keeps playing
        pulse(0, 0, 0, 1);
        chk_out("play3", 1, 3, 0, 1);
        bus.auto_advance = 1'b1;
        pulse(0, 0, 1, 0);
        chk_out("auto_r1", 0, 0, 1, 2);
        step();
        chk_out("auto_r2", 0, 0, 1, 2);
        step();
        chk_out("auto_resume", 1, 0, 0, 1);

        // reach song 2 while playing
        pulse(1, 0, 0, 0);
        step();
        step();
        pulse(1, 0, 0, 0);
        step();
        step();
        chk_out("play2", 1, 2, 0, 1);

        // song_done without auto_advance, play_button dropped
        bus.auto_advance = 1'b0;
        pulse(0, 0, 1, 1);
        chk_out("noauto_r1", 0, 2, 1, 2);
        step();
        chk_out("noauto_r2", 0, 2, 1, 2);
        step();
        chk_out("noauto_pause", 0, 2, 0, 0);

        // song_done in PAUSED is ignored
        pulse(0, 0, 1, 0);
        chk_out("done_paused", 0, 2, 0, 0);

        // next beats prev in the same cycle
        pulse(1, 1, 0, 0);
        chk_out("prio_r1", 0, 3, 1, 2);
        step();
        step();
        chk_out("prio_pause", 0, 3, 0, 0);

        // next during RESETTING is ignored
        pulse(1, 0, 0, 0);
        chk_out("ign_r1", 0, 0, 1, 2);
        pulse(1, 0, 0, 0);
        chk_out("ign_r2", 0, 0, 1, 2);
        step();
        chk_out("ign_pause", 0, 0, 0, 0);

        // reset mid-RESETTING
        pulse(0, 0, 0, 1);
        chk_out("play_again", 1, 0, 0, 1);
        pulse(1, 0, 0, 0);
        chk_out("mid_r1", 0, 1, 1, 2);
        reset = 1'b1;
        step();
        chk_out("mid_reset", 0, 0, 0, 0);
        reset = 1'b0;
        step();
        step();
        chk_out("after_reset", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
